mac_dot_pipe: RTL and testbench

//  Parametrised, pipelined signed dot-product accumulator for the CNN datapath.

---
 rtl/mac_dot_pipe.sv | 165 ++++++++++++++++
 tb/tb_mac_dot_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_pipe.sv
// Pipelined signed dot-product accumulator: LANES multipliers, a reduction tree,
// and an accumulator that emits one total per vector on a valid/ready output.
module mac_dot_pipe #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned A_W    = 8,
    parameter int unsigned B_W    = 8,
    parameter int unsigned ACC_W  = 32,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [LANES*A_W-1:0]   a,
    input  logic [LANES*B_W-1:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_acc,
    output logic                   out_sat
);

    localparam int unsigned PW = A_W + B_W;
    localparam int unsigned SW = PW + $clog2(LANES);
    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

    logic                      s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [LANES-1:0][PW-1:0]  s1_prod_q, s1_prod_d;
    logic                      s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [SW-1:0]             s2_sum_q, s2_sum_d;
    logic                      s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
    logic [SW-1:0]             s3_sum_q, s3_sum_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic                      sat_q, sat_d;
    logic                      out_valid_q, out_valid_d;
    logic [ACC_W-1:0]          out_acc_q, out_acc_d;
    logic                      out_sat_q, out_sat_d;

    logic                      stall, accept, ovf;
    logic [LANES-1:0][PW-1:0]  prod_c;
    logic [SW-1:0]             sum_c;
    logic [ACC_W:0]            acc_sum;
    logic [ACC_W-1:0]          acc_res;

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall && !clr;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_sat   = out_sat_q;

    // Operands are sign-extended to PW first so the low PW product bits are exact.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            prod_c[i] = PW'($signed(a[i*A_W +: A_W])) * PW'($signed(b[i*B_W +: B_W]));
        end
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum_c = sum_c + SW'($signed(s1_prod_q[i]));
        end
    end

    // One guard bit above the accumulator exposes signed overflow.
    always_comb begin
        acc_sum = {acc_q[ACC_W-1], acc_q} + (ACC_W+1)'($signed(s3_sum_q));
        ovf     = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
        if (ovf && SAT_EN) begin
            acc_res = acc_sum[ACC_W] ? AccMin : AccMax;
        end else begin
            acc_res = acc_sum[ACC_W-1:0];
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_prod_d   = s1_prod_q;
        s2_valid_d  = s2_valid_q;
        s2_last_d   = s2_last_q;
        s2_sum_d    = s2_sum_q;
        s3_valid_d  = s3_valid_q;
        s3_last_d   = s3_last_q;
        s3_sum_d    = s3_sum_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_sat_d   = out_sat_q;

        if (clr) begin
            // Pipeline flushes; a pending result in the output register survives.
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            s3_valid_d = 1'b0;
            acc_d      = '0;
            sat_d      = 1'b0;
            if (!stall) begin
                out_valid_d = 1'b0;
            end
        end else if (!stall) begin
            s1_valid_d  = accept;
            s1_last_d   = in_last;
            s1_prod_d   = prod_c;
            s2_valid_d  = s1_valid_q;
            s2_last_d   = s1_last_q;
            s2_sum_d    = sum_c;
            s3_valid_d  = s2_valid_q;
            s3_last_d   = s2_last_q;
            s3_sum_d    = s2_sum_q;
            out_valid_d = 1'b0;
            if (s3_valid_q) begin
                if (s3_last_q) begin
                    out_valid_d = 1'b1;
                    out_acc_d   = acc_res;
                    out_sat_d   = sat_q | ovf;
                    acc_d       = '0;
                    sat_d       = 1'b0;
                end else begin
                    acc_d = acc_res;
                    sat_d = sat_q | ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_prod_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_sum_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_sum_q    <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_prod_q   <= s1_prod_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_sum_q    <= s2_sum_d;
            s3_valid_q  <= s3_valid_d;
            s3_last_q   <= s3_last_d;
            s3_sum_q    <= s3_sum_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_mac_dot_pipe.sv
// Randomized bench for mac_dot_pipe: a 32-bit saturating instance plus 20-bit
// saturating and wrapping instances share stimulus and are scored against a model.
module tb_mac_dot_pipe;

    typedef logic [31:0] vec_t [16];
    typedef struct { longint m; longint s; longint w; bit sm; bit ss; bit sw; } res_t;
    localparam longint NoResult = 64'sh7fff_ffff_ffff_ffff;

    logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        in_ready_m, in_ready_s, in_ready_w, ov_m, ov_s, ov_w, sat_m, sat_s, sat_w;
    logic [31:0] acc_m;
    logic [19:0] acc_s, acc_w;

    int   n_cmp = 0, n_bad = 0;
    res_t exp_q[$], obs_q[$], seen[$];
    res_t e, o;

    mac_dot_pipe #(.LANES(4), .A_W(8), .B_W(8), .ACC_W(32), .SAT_EN(1'b1)) u_main (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_last(in_last), .a(a), .b(b), .out_valid(ov_m), .out_ready(out_ready),
        .out_acc(acc_m), .out_sat(sat_m));
    mac_dot_pipe #(.LANES(4), .A_W(8), .B_W(8), .ACC_W(20), .SAT_EN(1'b1)) u_sat20 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_last(in_last), .a(a), .b(b), .out_valid(ov_s), .out_ready(out_ready),
        .out_acc(acc_s), .out_sat(sat_s));
    mac_dot_pipe #(.LANES(4), .A_W(8), .B_W(8), .ACC_W(20), .SAT_EN(1'b0)) u_wrap20 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_last(in_last), .a(a), .b(b), .out_valid(ov_w), .out_ready(out_ready),
        .out_acc(acc_w), .out_sat(sat_w));

    always #5 clk = ~clk;

    // Records each completed output handshake, sampled mid-low-phase.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_ready && ov_m) begin
            obs_q.push_back('{m: longint'($signed(acc_m)),
                              s: ov_s ? longint'($signed(acc_s)) : NoResult,
                              w: ov_w ? longint'($signed(acc_w)) : NoResult,
                              sm: sat_m, ss: sat_s, sw: sat_w});
        end
    end

    function automatic longint dot4(input logic [31:0] av, input logic [31:0] bv);
        longint s = 0;
        for (int i = 0; i < 4; i++) begin
            s += longint'($signed(av[i*8 +: 8])) * longint'($signed(bv[i*8 +: 8]));
        end
        return s;
    endfunction

    task automatic step(inout longint acc, inout bit sat, input longint d, input int w,
                        input bit sat_en);
        longint lim, t;
        lim = longint'(1) <<< (w - 1);
        t   = acc + d;
        if (t >= lim || t < -lim) begin
            sat = 1'b1;
            if (sat_en) t = (t >= lim) ? lim - 1 : -lim;
            else begin
                t = t & (2 * lim - 1);
                if (t >= lim) t -= 2 * lim;
            end
        end
        acc = t;
    endtask

    task automatic drive_beat(input logic [31:0] av, input logic [31:0] bv, input logic last);
        bit done = 1'b0;
        in_valid = 1'b1; a = av; b = bv; in_last = last;
        for (int t = 0; t < 300 && !done; t++) begin
            #1;
            done = in_ready_m;
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL beat_accept: in_ready stayed 0 for 300 cycles, need 1");
        end
    endtask

    task automatic send_vec(input vec_t av, input vec_t bv, input int n);
        res_t r = '{m: 0, s: 0, w: 0, sm: 0, ss: 0, sw: 0};
        for (int k = 0; k < n; k++) begin
            step(r.m, r.sm, dot4(av[k], bv[k]), 32, 1'b1);
            step(r.s, r.ss, dot4(av[k], bv[k]), 20, 1'b1);
            step(r.w, r.sw, dot4(av[k], bv[k]), 20, 1'b0);
        end
        exp_q.push_back(r);
        for (int k = 0; k < n; k++) drive_beat(av[k], bv[k], k == n - 1);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h8080_8080;
            1:       return 32'h7f7f_7f7f;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        vec_t va, vb;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ov_m !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b need 0", ov_m); end
        n_cmp++; if (acc_m !== 32'd0) begin n_bad++; $display("FAIL reset_acc: got %0d need 0", acc_m); end
        n_cmp++; if (sat_m !== 1'b0) begin n_bad++; $display("FAIL reset_sat: got %b need 0", sat_m); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready_m !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b need 1", in_ready_m); end
        @(negedge clk);
        // Hold a result, start another vector, then reset asynchronously mid-vector.
        out_ready = 1'b0;
        va[0] = 32'h0102_0304; vb[0] = 32'h0506_0708;
        send_vec(va, vb, 1);
        drive_beat(rnd_word(), rnd_word(), 1'b0);
        repeat (4) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (ov_m !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b need 0", ov_m); end
        n_cmp++; if (acc_m !== 32'd0) begin n_bad++; $display("FAIL midreset_acc: got %0d need 0", acc_m); end
        n_cmp++; if (sat_m !== 1'b0) begin n_bad++; $display("FAIL midreset_sat: got %b need 0", sat_m); end
        exp_q.delete(); obs_q.delete();
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready_m !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %b need 1", in_ready_m); end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin va[k] = rnd_word(); vb[k] = rnd_word(); end
        send_vec(va, vb, 3);
        for (int t = 0; t < 400 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL t1_count: got %0d results need %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o.m !== e.m || o.sm !== e.sm || o.s !== e.s || o.ss !== e.ss || o.w !== e.w || o.sw !== e.sw) begin
                n_bad++; $display("FAIL t1_total: got %0d/%0d %0d/%0d %0d/%0d need %0d/%0d %0d/%0d %0d/%0d",
                    o.m, o.sm, o.s, o.ss, o.w, o.sw, e.m, e.sm, e.s, e.ss, e.w, e.sw);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_single_beat();
        vec_t va, vb;
        int cyc = 0;
        va[0] = 32'h0403_0201; vb[0] = 32'h0807_0605;
        send_vec(va, vb, 1);
        #1;
        while (!ov_m && cyc < 20) begin @(negedge clk); #1; cyc++; end
        n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL t2_latency: got %0d cycles need 3", cyc); end
        n_cmp++; if (acc_m !== 32'd70) begin n_bad++; $display("FAIL t2_acc: got %0d need 70", acc_m); end
        n_cmp++; if (sat_m !== 1'b0) begin n_bad++; $display("FAIL t2_sat: got %b need 0", sat_m); end
        @(negedge clk);
        for (int t = 0; t < 400 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL t2_count: got %0d results need %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o.m !== e.m || o.sm !== e.sm || o.s !== e.s || o.ss !== e.ss || o.w !== e.w || o.sw !== e.sw) begin
                n_bad++; $display("FAIL t2_total: got %0d/%0d %0d/%0d %0d/%0d need %0d/%0d %0d/%0d %0d/%0d",
                    o.m, o.sm, o.s, o.ss, o.w, o.sw, e.m, e.sm, e.s, e.ss, e.w, e.sw);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_sign_extremes();
        vec_t va, vb;
        seen.delete();
        for (int k = 0; k < 3; k++) begin va[k] = 32'h8080_8080; vb[k] = 32'h8080_8080; end
        send_vec(va, vb, 3);
        va[0] = 32'h8080_8080; vb[0] = 32'h7f7f_7f7f;
        send_vec(va, vb, 1);
        for (int t = 0; t < 400 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL t3_count: got %0d results need %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); seen.push_back(o); n_cmp++;
            if (o.m !== e.m || o.sm !== e.sm || o.s !== e.s || o.ss !== e.ss || o.w !== e.w || o.sw !== e.sw) begin
                n_bad++; $display("FAIL t3_total: got %0d/%0d %0d/%0d %0d/%0d need %0d/%0d %0d/%0d %0d/%0d",
                    o.m, o.sm, o.s, o.ss, o.w, o.sw, e.m, e.sm, e.s, e.ss, e.w, e.sw);
            end
        end
        exp_q.delete(); obs_q.delete();
        if (seen.size() == 2) begin
            n_cmp++; if (seen[0].m !== longint'(196608)) begin n_bad++; $display("FAIL t3_pos: got %0d need 196608", seen[0].m); end
            n_cmp++; if (seen[1].m !== longint'(-65024)) begin n_bad++; $display("FAIL t3_neg: got %0d need -65024", seen[1].m); end
        end
    endtask

    task automatic test_saturation();
        vec_t va, vb;
        seen.delete();
        for (int k = 0; k < 9; k++) begin va[k] = 32'h8080_8080; vb[k] = 32'h8080_8080; end
        send_vec(va, vb, 9);
        va[0] = 32'h0101_0101; vb[0] = 32'h0202_0202;
        send_vec(va, vb, 1);
        for (int t = 0; t < 400 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL t4_count: got %0d results need %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); seen.push_back(o); n_cmp++;
            if (o.m !== e.m || o.sm !== e.sm || o.s !== e.s || o.ss !== e.ss || o.w !== e.w || o.sw !== e.sw) begin
                n_bad++; $display("FAIL t4_total: got %0d/%0d %0d/%0d %0d/%0d need %0d/%0d %0d/%0d %0d/%0d",
                    o.m, o.sm, o.s, o.ss, o.w, o.sw, e.m, e.sm, e.s, e.ss, e.w, e.sw);
            end
        end
        exp_q.delete(); obs_q.delete();
        if (seen.size() == 2) begin
            n_cmp++; if (seen[0].s !== longint'(524287) || seen[0].ss !== 1'b1) begin
                n_bad++; $display("FAIL t4_clamp: got %0d/%0d need 524287/1", seen[0].s, seen[0].ss); end
            n_cmp++; if (seen[0].w !== longint'(-458752) || seen[0].sw !== 1'b1) begin
                n_bad++; $display("FAIL t4_wrap: got %0d/%0d need -458752/1", seen[0].w, seen[0].sw); end
            n_cmp++; if (seen[1].ss !== 1'b0 || seen[1].sw !== 1'b0 || seen[1].s !== longint'(8)) begin
                n_bad++; $display("FAIL t4_next: got %0d/%0d/%0d need 8/0/0", seen[1].s, seen[1].ss, seen[1].sw); end
        end
    endtask

    task automatic test_backpressure();
        vec_t va, vb;
        out_ready = 1'b0;
        fork
            for (int v = 0; v < 4; v++) begin
                va[0] = rnd_word(); vb[0] = rnd_word();
                send_vec(va, vb, 1);
            end
            begin
                logic [31:0] held = '0;
                bit have = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    #1;
                    if (ov_m) begin
                        if (have) begin
                            n_cmp++; if (acc_m !== held) begin n_bad++; $display("FAIL t5_hold: got %0d need %0d", acc_m, held); end
                        end else begin
                            held = acc_m; have = 1'b1;
                        end
                        n_cmp++; if (in_ready_m !== 1'b0) begin n_bad++; $display("FAIL t5_ready: got %b need 0", in_ready_m); end
                        n_cmp++; if (in_ready_s !== in_ready_m || in_ready_w !== in_ready_m) begin
                            n_bad++; $display("FAIL t5_ready_agree: got %b%b need %b", in_ready_s, in_ready_w, in_ready_m); end
                    end
                end
                n_cmp++; if (!have) begin n_bad++; $display("FAIL t5_held: got no result need one held"); end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 400 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL t5_count: got %0d results need %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o.m !== e.m || o.sm !== e.sm || o.s !== e.s || o.ss !== e.ss || o.w !== e.w || o.sw !== e.sw) begin
                n_bad++; $display("FAIL t5_total: got %0d/%0d %0d/%0d %0d/%0d need %0d/%0d %0d/%0d %0d/%0d",
                    o.m, o.sm, o.s, o.ss, o.w, o.sw, e.m, e.sm, e.s, e.ss, e.w, e.sw);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_clr();
        vec_t va, vb;
        for (int gap = 0; gap <= 4; gap += 4) begin
            drive_beat(rnd_word(), rnd_word(), 1'b0);
            drive_beat(rnd_word(), rnd_word(), 1'b0);
            repeat (gap) @(negedge clk);
            clr = 1'b1;
            #1;
            n_cmp++; if (in_ready_m !== 1'b0) begin n_bad++; $display("FAIL t6_ready: got %b need 0", in_ready_m); end
            @(negedge clk);
            clr = 1'b0;
            for (int k = 0; k < 2; k++) begin va[k] = rnd_word(); vb[k] = rnd_word(); end
            send_vec(va, vb, 2);
            for (int t = 0; t < 400 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
            repeat (6) @(negedge clk);
            n_cmp++;
            if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL t6_count: got %0d results need %0d", obs_q.size(), exp_q.size()); end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
                if (o.m !== e.m || o.sm !== e.sm || o.s !== e.s || o.ss !== e.ss || o.w !== e.w || o.sw !== e.sw) begin
                    n_bad++; $display("FAIL t6_total: got %0d/%0d %0d/%0d %0d/%0d need %0d/%0d %0d/%0d %0d/%0d",
                        o.m, o.sm, o.s, o.ss, o.w, o.sw, e.m, e.sm, e.s, e.ss, e.w, e.sw);
                end
            end
            exp_q.delete(); obs_q.delete();
        end
    endtask

    task automatic test_random();
        vec_t va, vb;
        bit done = 1'b0;
        fork
            begin
                for (int v = 0; v < 25; v++) begin
                    int n = int'($urandom_range(1, 12));
                    for (int k = 0; k < n; k++) begin va[k] = rnd_word(); vb[k] = rnd_word(); end
                    send_vec(va, vb, n);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 400 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rnd_count: got %0d results need %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o.m !== e.m || o.sm !== e.sm || o.s !== e.s || o.ss !== e.ss || o.w !== e.w || o.sw !== e.sw) begin
                n_bad++; $display("FAIL rnd_total: got %0d/%0d %0d/%0d %0d/%0d need %0d/%0d %0d/%0d %0d/%0d",
                    o.m, o.sm, o.s, o.ss, o.w, o.sw, e.m, e.sm, e.s, e.ss, e.w, e.sw);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, need finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_sign_extremes();
        test_saturation();
        test_backpressure();
        test_clr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
